data_mem_ctrl: RTL

- Parametrised, byte-addressed data memory for the single-cycle/multi-cycle core's load/store path.
- Adds to the basic data memory:
  - valid/ready request handshake and registered response with configurable wait states
  - little-endian byte lanes, zero-extended loads (LBU/LHU)
  - misaligned, out-of-range and illegal-func3 error reporting
- Sits between the ALU/LSU address path and the writeback mux.

---
 rtl/data_mem_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory for the core's load/store path.
// A request is accepted in IDLE, optionally held for WAIT_STATES cycles, and
// answered with a one-cycle rsp_valid strobe. Loads support LB/LH/LW/LBU/LHU
// and stores support SB/SH/SW, with little-endian byte lanes. Misaligned,
// out-of-range and illegal-func3 accesses write nothing and return rsp_err=1
// with rsp_rdata=0, using the same timing as a normal access.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (accept when both high at an edge)
//   req_write             1 = store, 0 = load
//   func3                 RISC-V funct3 (size and sign mode)
//   addr, wdata           byte address and store data
//   rsp_valid             one-cycle response strobe
//   rsp_rdata, rsp_err    registered load result and fault flag, held until
//                         the next response
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [2:0]  func3_q, func3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Operands of the access being completed. With no wait states the access
    // completes on its accept edge, so the live inputs are used directly.
    logic            a_write;
    logic [2:0]      a_func3;
    logic [31:0]     a_addr;
    logic [31:0]     a_wdata;
    logic            a_err;
    logic            enter_resp;
    logic            we;
    logic [IdxW-1:0] idx;
    logic [31:0]     word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_val;
    logic [3:0]      be;
    logic [31:0]     wlane;
    logic            legal;
    logic            misaligned;
    logic            oob;

    always_comb begin
        if (state_q == StIdle) begin
            a_write = req_write;
            a_func3 = func3;
            a_addr  = addr;
            a_wdata = wdata;
        end else begin
            a_write = write_q;
            a_func3 = func3_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
        end
    end

    assign enter_resp = ((state_q == StIdle) && req_valid && (WAIT_STATES == 0)) ||
                        ((state_q == StWait) && (cnt_q == 3'd0));

    // Error checks
    always_comb begin
        if (a_write) begin
            legal = a_func3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = a_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        misaligned = ((a_func3[1:0] == 2'b01) && a_addr[0]) ||
                     ((a_func3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
        // No aliasing: any set bit above the array index is out of range.
        oob   = {2'b00, a_addr[31:2]} >= DEPTH_WORDS;
        a_err = !legal || misaligned || oob;
    end

    assign idx      = a_addr[IdxW+1:2];
    assign word     = mem[idx];
    assign byte_sel = word[{a_addr[1:0], 3'b000} +: 8];
    assign half_sel = a_addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (a_func3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = word;
        endcase
    end

    always_comb begin
        case (a_func3[1:0])
            2'b00: begin
                be    = 4'b0001 << a_addr[1:0];
                wlane = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be    = a_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{a_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = a_wdata;
            end
        endcase
    end

    // rst_n gates the write so a store completing under reset is dropped.
    assign we = enter_resp && a_write && !a_err && rst_n;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    func3_d = func3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 3'(WAIT_STATES - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (enter_resp) begin
            err_d   = a_err;
            rdata_d = (a_err || a_write) ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            write_q <= 1'b0;
            func3_q <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
